// File: rtl/fix_checksum_gen.sv
// FIX tag-10 checksum engine: sums enabled body bytes mod 256 from SEED, presents the
// result as binary, 3-digit ASCII and a serial ASCII digit stream, and checks it against "10=".
module fix_checksum_gen #(
  parameter int         LANES = 1,
  parameter logic [7:0] SEED  = 8'd0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [8*LANES-1:0] s_data,
  input  logic [LANES-1:0]   s_keep,
  input  logic               s_last,
  input  logic               exp_valid,
  input  logic [23:0]        exp_ascii,
  output logic               cks_valid,
  output logic [7:0]         cks_bin,
  output logic [23:0]        cks_ascii,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [7:0]         m_data,
  output logic               match_valid,
  output logic               match
);

  typedef enum logic [2:0] {IDLE, ACCUM, DONE, EMIT0, EMIT1, EMIT2} state_t;

  state_t      state;
  logic [7:0]  sum;
  logic [10:0] lane_sum;
  logic [7:0]  dig_h;
  logic [7:0]  dig_t;
  logic [7:0]  dig_u;
  logic [23:0] exp_q;
  logic        exp_pending;
  logic        armed;
  logic        beat;
  logic        first_beat;
  logic        eff_pending;
  logic [23:0] eff_exp;
  logic        fire;

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      if (s_keep[i]) lane_sum = lane_sum + {3'b000, s_data[8*i +: 8]};
    end
  end

  assign dig_h = (sum / 8'd100) + 8'h30;
  assign dig_t = ((sum % 8'd100) / 8'd10) + 8'h30;
  assign dig_u = (sum % 8'd10) + 8'h30;

  assign s_ready    = rst && ((state == IDLE) || (state == ACCUM));
  assign beat       = s_valid && s_ready;
  assign first_beat = beat && (state == IDLE);

  // A strobe in the same cycle as the result is compared directly, bypassing exp_q.
  assign eff_pending = exp_pending || exp_valid;
  assign eff_exp     = exp_valid ? exp_ascii : exp_q;
  assign fire        = armed && eff_pending && !first_beat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sum       <= SEED;
      cks_valid <= 1'b0;
      cks_bin   <= 8'd0;
      cks_ascii <= 24'h303030;
      m_valid   <= 1'b0;
      m_data    <= 8'h30;
    end else begin
      cks_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (beat) begin
            sum   <= SEED + lane_sum[7:0];
            state <= s_last ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (beat) begin
            sum <= sum + lane_sum[7:0];
            if (s_last) state <= DONE;
          end
        end
        DONE: begin
          cks_bin   <= sum;
          cks_ascii <= {dig_h, dig_t, dig_u};
          cks_valid <= 1'b1;
          m_valid   <= 1'b1;
          m_data    <= dig_h;
          state     <= EMIT0;
        end
        EMIT0: begin
          if (m_ready) begin
            m_data <= cks_ascii[15:8];
            state  <= EMIT1;
          end
        end
        EMIT1: begin
          if (m_ready) begin
            m_data <= cks_ascii[7:0];
            state  <= EMIT2;
          end
        end
        EMIT2: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // armed marks "this message's result exists and has not been compared yet".
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q       <= 24'd0;
      exp_pending <= 1'b0;
      armed       <= 1'b0;
      match_valid <= 1'b0;
      match       <= 1'b0;
    end else begin
      match_valid <= fire;
      if (fire) match <= (eff_exp == cks_ascii);
      if (exp_valid) exp_q <= exp_ascii;
      if (fire || (first_beat && !exp_valid)) exp_pending <= 1'b0;
      else if (exp_valid) exp_pending <= 1'b1;
      if (state == DONE) armed <= 1'b1;
      else if (fire || first_beat) armed <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fix_checksum_gen.sv
// Directed bench for fix_checksum_gen: LANES=1/SEED=0, LANES=4/SEED=0 and LANES=1/SEED=117 instances.
module tb_fix_checksum_gen;

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic [7:0]  s_data;
  logic [0:0]  s_keep;
  logic        s_last;
  logic        exp_valid;
  logic [23:0] exp_ascii;
  logic        m_ready;

  logic        s_ready1, cks_valid1, m_valid1, match_valid1, match1;
  logic [7:0]  cks_bin1, m_data1;
  logic [23:0] cks_ascii1;

  logic        s_ready_s, cks_valid_s, m_valid_s, match_valid_s, match_s;
  logic [7:0]  cks_bin_s, m_data_s;
  logic [23:0] cks_ascii_s;

  logic        s_valid4, s_last4;
  logic [31:0] s_data4;
  logic [3:0]  s_keep4;
  logic        s_ready4, cks_valid4, m_valid4, match_valid4, match4;
  logic [7:0]  cks_bin4, m_data4;
  logic [23:0] cks_ascii4;

  int tests;
  int failed;

  fix_checksum_gen #(.LANES(1), .SEED(8'd0)) u1 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready1), .s_data(s_data),
    .s_keep(s_keep), .s_last(s_last), .exp_valid(exp_valid), .exp_ascii(exp_ascii),
    .cks_valid(cks_valid1), .cks_bin(cks_bin1), .cks_ascii(cks_ascii1), .m_valid(m_valid1),
    .m_ready(m_ready), .m_data(m_data1), .match_valid(match_valid1), .match(match1));

  fix_checksum_gen #(.LANES(1), .SEED(8'd117)) us (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_s), .s_data(s_data),
    .s_keep(s_keep), .s_last(s_last), .exp_valid(exp_valid), .exp_ascii(exp_ascii),
    .cks_valid(cks_valid_s), .cks_bin(cks_bin_s), .cks_ascii(cks_ascii_s), .m_valid(m_valid_s),
    .m_ready(m_ready), .m_data(m_data_s), .match_valid(match_valid_s), .match(match_s));

  fix_checksum_gen #(.LANES(4), .SEED(8'd0)) u4 (
    .clk(clk), .rst(rst), .s_valid(s_valid4), .s_ready(s_ready4), .s_data(s_data4),
    .s_keep(s_keep4), .s_last(s_last4), .exp_valid(1'b0), .exp_ascii(24'd0),
    .cks_valid(cks_valid4), .cks_bin(cks_bin4), .cks_ascii(cks_ascii4), .m_valid(m_valid4),
    .m_ready(m_ready), .m_data(m_data4), .match_valid(match_valid4), .match(match4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one byte on the shared LANES=1 stream and returns just after it is accepted.
  task automatic send_byte(input logic [7:0] d, input logic l);
    int n;
    s_valid = 1'b1; s_data = d; s_keep = 1'b1; s_last = l;
    n = 0;
    while (!s_ready1 && n < 20) begin step(); n++; end
    if (!s_ready1) begin
      tests++; failed++;
      $display("[TB] FAIL send_timeout: s_ready %0b required 1", s_ready1);
    end
    step();
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step(); step();
    tests++; if (s_ready1 !== 1'b0) begin failed++; $display("[TB] FAIL rst_s_ready got %0b exp 0", s_ready1); end
    tests++; if (cks_bin1 !== 8'd0) begin failed++; $display("[TB] FAIL rst_cks_bin got %0d exp 0", cks_bin1); end
    tests++; if (cks_ascii1 !== 24'h303030) begin failed++; $display("[TB] FAIL rst_cks_ascii got %h exp 303030", cks_ascii1); end
    tests++; if (m_data1 !== 8'h30) begin failed++; $display("[TB] FAIL rst_m_data got %h exp 30", m_data1); end
    tests++; if ({cks_valid1, m_valid1, match_valid1, match1} !== 4'b0000) begin failed++; $display("[TB] FAIL rst_strobes got %b exp 0000", {cks_valid1, m_valid1, match_valid1, match1}); end
    rst = 1'b1;
    #1;
    tests++; if (s_ready1 !== 1'b1) begin failed++; $display("[TB] FAIL rst_release_ready got %0b exp 1", s_ready1); end
  endtask

  task automatic test_abc();
    m_ready = 1'b1;
    send_byte(8'h41, 1'b0); send_byte(8'h42, 1'b0); send_byte(8'h43, 1'b1);
    tests++; if (cks_valid1 !== 1'b0) begin failed++; $display("[TB] FAIL abc_early_valid got %0b exp 0", cks_valid1); end
    tests++; if (s_ready1 !== 1'b0) begin failed++; $display("[TB] FAIL abc_done_ready got %0b exp 0", s_ready1); end
    step();
    tests++; if (cks_valid1 !== 1'b1) begin failed++; $display("[TB] FAIL abc_cks_valid got %0b exp 1", cks_valid1); end
    tests++; if (cks_bin1 !== 8'd198) begin failed++; $display("[TB] FAIL abc_cks_bin got %0d exp 198", cks_bin1); end
    tests++; if (cks_ascii1 !== 24'h313938) begin failed++; $display("[TB] FAIL abc_cks_ascii got %h exp 313938", cks_ascii1); end
    tests++; if ({m_valid1, m_data1} !== {1'b1, 8'h31}) begin failed++; $display("[TB] FAIL abc_digit0 got %b/%h exp 1/31", m_valid1, m_data1); end
    step();
    tests++; if ({cks_valid1, m_data1} !== {1'b0, 8'h39}) begin failed++; $display("[TB] FAIL abc_digit1 got %b/%h exp 0/39", cks_valid1, m_data1); end
    step();
    tests++; if (m_data1 !== 8'h38) begin failed++; $display("[TB] FAIL abc_digit2 got %h exp 38", m_data1); end
    step();
    tests++; if ({m_valid1, s_ready1} !== 2'b01) begin failed++; $display("[TB] FAIL abc_back_idle got %b exp 01", {m_valid1, s_ready1}); end
  endtask

  task automatic test_wrap();
    m_ready = 1'b1;
    send_byte(8'hFF, 1'b0); send_byte(8'hFF, 1'b0); send_byte(8'hFF, 1'b0); send_byte(8'hFF, 1'b1);
    step();
    tests++; if (cks_bin1 !== 8'd252) begin failed++; $display("[TB] FAIL wrap_cks_bin got %0d exp 252", cks_bin1); end
    tests++; if (m_data1 !== 8'h32) begin failed++; $display("[TB] FAIL wrap_digit0 got %h exp 32", m_data1); end
    step();
    tests++; if (m_data1 !== 8'h35) begin failed++; $display("[TB] FAIL wrap_digit1 got %h exp 35", m_data1); end
    step();
    tests++; if (m_data1 !== 8'h32) begin failed++; $display("[TB] FAIL wrap_digit2 got %h exp 32", m_data1); end
    step();
  endtask

  task automatic test_lanes4();
    m_ready = 1'b1;
    tests++; if (s_ready4 !== 1'b1) begin failed++; $display("[TB] FAIL l4_idle_ready got %0b exp 1", s_ready4); end
    s_valid4 = 1'b1; s_data4 = 32'h04030201; s_keep4 = 4'b0101; s_last4 = 1'b0;
    step();
    s_keep4 = 4'b0000; s_last4 = 1'b1;
    step();
    s_valid4 = 1'b0; s_last4 = 1'b0;
    tests++; if (s_ready4 !== 1'b0) begin failed++; $display("[TB] FAIL l4_done_ready got %0b exp 0", s_ready4); end
    step();
    tests++; if (cks_bin4 !== 8'd4) begin failed++; $display("[TB] FAIL l4_cks_bin got %0d exp 4", cks_bin4); end
    tests++; if (cks_ascii4 !== 24'h303034) begin failed++; $display("[TB] FAIL l4_cks_ascii got %h exp 303034", cks_ascii4); end
    tests++; if (s_ready4 !== 1'b0) begin failed++; $display("[TB] FAIL l4_emit0_ready got %0b exp 0", s_ready4); end
    step();
    tests++; if (s_ready4 !== 1'b0) begin failed++; $display("[TB] FAIL l4_emit1_ready got %0b exp 0", s_ready4); end
    step();
    tests++; if ({s_ready4, m_data4} !== {1'b0, 8'h34}) begin failed++; $display("[TB] FAIL l4_emit2 got %b/%h exp 0/34", s_ready4, m_data4); end
    step();
    tests++; if (s_ready4 !== 1'b1) begin failed++; $display("[TB] FAIL l4_back_idle got %0b exp 1", s_ready4); end
  endtask

  task automatic test_back_to_back();
    m_ready = 1'b0;
    send_byte(8'h41, 1'b0); send_byte(8'h42, 1'b0); send_byte(8'h43, 1'b1);
    // Next message's beat is held by the source while the digits drain.
    s_valid = 1'b1; s_data = 8'h05; s_keep = 1'b1; s_last = 1'b1;
    tests++; if (s_ready1 !== 1'b0) begin failed++; $display("[TB] FAIL stall_done_ready got %0b exp 0", s_ready1); end
    step();
    for (int i = 0; i < 5; i++) begin
      tests++; if ({m_valid1, m_data1, s_ready1} !== {1'b1, 8'h31, 1'b0}) begin failed++; $display("[TB] FAIL stall_hold%0d got %b/%h/%b exp 1/31/0", i, m_valid1, m_data1, s_ready1); end
      step();
    end
    m_ready = 1'b1;
    step();
    tests++; if (m_data1 !== 8'h39) begin failed++; $display("[TB] FAIL stall_digit1 got %h exp 39", m_data1); end
    step();
    tests++; if ({m_data1, s_ready1} !== {8'h38, 1'b0}) begin failed++; $display("[TB] FAIL stall_digit2 got %h/%b exp 38/0", m_data1, s_ready1); end
    step();
    tests++; if (s_ready1 !== 1'b1) begin failed++; $display("[TB] FAIL stall_idle_ready got %0b exp 1", s_ready1); end
    step();
    s_valid = 1'b0; s_last = 1'b0;
    step();
    tests++; if ({cks_valid1, cks_bin1} !== {1'b1, 8'd5}) begin failed++; $display("[TB] FAIL stall_next_msg got %b/%0d exp 1/5", cks_valid1, cks_bin1); end
    step(); step(); step();
  endtask

  task automatic test_compare();
    m_ready = 1'b1;
    send_byte(8'h41, 1'b0);
    exp_valid = 1'b1; exp_ascii = 24'h313938;
    send_byte(8'h42, 1'b0);
    exp_valid = 1'b0;
    send_byte(8'h43, 1'b1);
    step();
    tests++; if (match_valid1 !== 1'b0) begin failed++; $display("[TB] FAIL cmp_early got %0b exp 0", match_valid1); end
    step();
    tests++; if ({match_valid1, match1} !== 2'b11) begin failed++; $display("[TB] FAIL cmp_equal got %b exp 11", {match_valid1, match1}); end
    step();
    tests++; if (match_valid1 !== 1'b0) begin failed++; $display("[TB] FAIL cmp_once got %0b exp 0", match_valid1); end
    step();

    send_byte(8'h41, 1'b0);
    exp_valid = 1'b1; exp_ascii = 24'h313939;
    send_byte(8'h42, 1'b0);
    exp_valid = 1'b0;
    send_byte(8'h43, 1'b1);
    step(); step();
    tests++; if ({match_valid1, match1} !== 2'b10) begin failed++; $display("[TB] FAIL cmp_differ got %b exp 10", {match_valid1, match1}); end
    step(); step();

    send_byte(8'h41, 1'b0); send_byte(8'h42, 1'b0); send_byte(8'h43, 1'b1);
    step(); step(); step(); step(); step();
    tests++; if (match_valid1 !== 1'b0) begin failed++; $display("[TB] FAIL cmp_no_exp got %0b exp 0", match_valid1); end
    exp_valid = 1'b1; exp_ascii = 24'h313938;
    step();
    exp_valid = 1'b0;
    tests++; if ({match_valid1, match1} !== 2'b11) begin failed++; $display("[TB] FAIL cmp_late got %b exp 11", {match_valid1, match1}); end
    step();
    tests++; if (match_valid1 !== 1'b0) begin failed++; $display("[TB] FAIL cmp_late_once got %0b exp 0", match_valid1); end
  endtask

  task automatic test_seed_reset();
    m_ready = 1'b1;
    send_byte(8'h00, 1'b1);
    step();
    tests++; if ({cks_valid_s, cks_bin_s} !== {1'b1, 8'd117}) begin failed++; $display("[TB] FAIL seed_bin got %b/%0d exp 1/117", cks_valid_s, cks_bin_s); end
    tests++; if (cks_ascii_s !== 24'h313137) begin failed++; $display("[TB] FAIL seed_ascii got %h exp 313137", cks_ascii_s); end
    step(); step(); step();

    send_byte(8'h00, 1'b1);
    step(); step();
    tests++; if ({m_valid_s, m_data_s} !== {1'b1, 8'h31}) begin failed++; $display("[TB] FAIL seed_emit1 got %b/%h exp 1/31", m_valid_s, m_data_s); end
    rst = 1'b0;
    exp_valid = 1'b1; exp_ascii = 24'h313137;
    #1;
    tests++; if ({cks_bin_s, cks_ascii_s} !== {8'd0, 24'h303030}) begin failed++; $display("[TB] FAIL mid_rst_result got %0d/%h exp 0/303030", cks_bin_s, cks_ascii_s); end
    tests++; if ({m_valid_s, m_data_s, cks_valid_s, s_ready_s} !== {1'b0, 8'h30, 1'b0, 1'b0}) begin failed++; $display("[TB] FAIL mid_rst_stream got %b/%h/%b/%b exp 0/30/0/0", m_valid_s, m_data_s, cks_valid_s, s_ready_s); end
    tests++; if ({match_valid1, match1} !== 2'b00) begin failed++; $display("[TB] FAIL mid_rst_match got %b exp 00", {match_valid1, match1}); end
    step();
    exp_valid = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++; if ({match_valid_s, s_ready_s} !== 2'b01) begin failed++; $display("[TB] FAIL post_rst%0d got %b exp 01", i, {match_valid_s, s_ready_s}); end
    end
    send_byte(8'h00, 1'b1);
    step();
    tests++; if ({cks_bin_s, cks_bin1} !== {8'd117, 8'd0}) begin failed++; $display("[TB] FAIL post_rst_msg got %0d/%0d exp 117/0", cks_bin_s, cks_bin1); end
    step(); step(); step();
  endtask

  initial begin
    tests = 0; failed = 0;
    rst = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_keep = 1'b0; s_last = 1'b0;
    exp_valid = 1'b0; exp_ascii = 24'd0; m_ready = 1'b1;
    s_valid4 = 1'b0; s_data4 = 32'd0; s_keep4 = 4'd0; s_last4 = 1'b0;
    #1;
    test_reset();
    test_abc();
    test_wrap();
    test_lanes4();
    test_back_to_back();
    test_compare();
    test_seed_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
